set_level: RTL and testbench



---
 rtl/set_level.sv | 225 ++++++++++++++++++++++
 tb/tb_set_level.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/set_level.sv
// set_level: stimulus-side driver that resolves a named output slot and
// drives it to a commanded level, either permanently (SET) or for N cycles
// before restoring the previous level (SET_PULSE).
//
// Strings are carried as packed ASCII, STR_CHARS bytes each, last character
// in the least significant byte and unused leading bytes NUL. This is the
// layout a Verilog string literal takes when assigned to a wider vector.
//
// Handshake: a command is offered when i_sel_set & i_args_valid are both high
// on a rising edge. It is captured only while o_busy is low. A command offered
// while o_busy is high is dropped, and o_error pulses on the following cycle.
// Every captured command ends with exactly one pulse: o_done on success, or
// o_error on rejection.
module set_level #(
  parameter int                   ARGS_NB    = 5,
  parameter int                   SET_SIZE   = 5,
  parameter int                   SET_WIDTH  = 32,
  parameter logic [SET_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                   STR_CHARS  = 16,
  parameter int                   CNT_W      = 32,
  localparam int                  STR_W      = 8 * STR_CHARS,
  localparam int                  IDX_W      = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SET_SIZE-1:0][STR_W-1:0]      i_set_alias,
  input  logic                                i_sel_set,
  input  logic                                i_args_valid,
  input  logic [ARGS_NB-1:0][STR_W-1:0]       i_args,
  output logic [SET_SIZE-1:0][SET_WIDTH-1:0]  o_set,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_error,
  output logic [1:0]                          o_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_PULSE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [STR_W-1:0] OP_SET   = {{(STR_W-24){1'b0}}, "SET"};
  localparam logic [STR_W-1:0] OP_PULSE = {{(STR_W-72){1'b0}}, "SET_PULSE"};

  state_t                              r_state;
  state_t                              w_state_nxt;
  logic [STR_W-1:0]                    r_opcode;
  logic [STR_W-1:0]                    r_alias;
  logic [STR_W-1:0]                    r_value_str;
  logic [STR_W-1:0]                    r_count_str;
  logic [SET_SIZE-1:0][SET_WIDTH-1:0]  r_set;
  logic [SET_WIDTH-1:0]                r_saved;
  logic [CNT_W-1:0]                    r_cnt;
  logic [IDX_W-1:0]                    r_idx;
  logic                                r_done;
  logic                                r_error;

  logic                                w_cmd;
  logic                                w_hit;
  logic [IDX_W-1:0]                    w_idx;
  logic [SET_WIDTH-1:0]                w_value;
  logic                                w_hex_ok;
  logic [CNT_W-1:0]                    w_count;
  logic                                w_dec_ok;
  logic                                w_is_set;
  logic                                w_is_pulse;
  logic                                w_dec_err;

  assign w_cmd      = i_sel_set & i_args_valid;
  assign w_is_set   = (r_opcode == OP_SET);
  assign w_is_pulse = (r_opcode == OP_PULSE);

  // Only arguments 0..3 carry meaning; any further arguments are ignored.
  generate
    if (ARGS_NB > 4) begin : g_extra_args
      logic w_unused_args;
      assign w_unused_args = ^i_args[ARGS_NB-1:4];
    end
  endgenerate

  // Alias lookup: scan downward so the lowest matching slot wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = SET_SIZE - 1; i >= 0; i--) begin
      if (i_set_alias[i] == r_alias) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  // Hex parse of the value: NUL padding first, then at least one hex digit.
  // Shifting into a SET_WIDTH accumulator keeps only the low-order bits.
  always_comb begin
    logic       seen;
    logic       bad;
    logic [7:0] c;
    logic [3:0] d;
    w_value = '0;
    seen    = 1'b0;
    bad     = 1'b0;
    for (int i = STR_CHARS - 1; i >= 0; i--) begin
      c = r_value_str[8*i +: 8];
      d = 4'd0;
      if (c == 8'h00) begin
        if (seen) bad = 1'b1;
      end else begin
        seen = 1'b1;
        if (c >= 8'h30 && c <= 8'h39)      d = 4'(c - 8'h30);
        else if (c >= 8'h41 && c <= 8'h46) d = 4'(c - 8'h37);
        else if (c >= 8'h61 && c <= 8'h66) d = 4'(c - 8'h57);
        else                               bad = 1'b1;
        w_value = SET_WIDTH'({w_value, d});
      end
    end
    w_hex_ok = seen & ~bad;
  end

  // Decimal parse of the pulse length, same padding rules as the value.
  always_comb begin
    logic       seen;
    logic       bad;
    logic [7:0] c;
    logic [3:0] d;
    w_count = '0;
    seen    = 1'b0;
    bad     = 1'b0;
    for (int i = STR_CHARS - 1; i >= 0; i--) begin
      c = r_count_str[8*i +: 8];
      d = 4'd0;
      if (c == 8'h00) begin
        if (seen) bad = 1'b1;
      end else begin
        seen = 1'b1;
        if (c >= 8'h30 && c <= 8'h39) d = 4'(c - 8'h30);
        else                          bad = 1'b1;
        w_count = (w_count * CNT_W'(10)) + {{(CNT_W-4){1'b0}}, d};
      end
    end
    w_dec_ok = seen & ~bad;
  end

  // A captured command is rejected when any field fails to resolve.
  always_comb begin
    w_dec_err = ~w_hit | ~(w_is_set | w_is_pulse) | ~w_hex_ok |
                (w_is_pulse & (~w_dec_ok | (w_count == '0)));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_cmd) w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_dec_err)       w_state_nxt = S_IDLE;
        else if (w_is_pulse) w_state_nxt = S_PULSE;
        else                 w_state_nxt = S_DONE;
      end
      S_PULSE:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: argument capture, slot updates, pulse timing, status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode    <= '0;
      r_alias     <= '0;
      r_value_str <= '0;
      r_count_str <= '0;
      r_set       <= {SET_SIZE{INIT_VALUE}};
      r_saved     <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done  <= (r_state == S_DONE);
      r_error <= ((r_state == S_DECODE) && w_dec_err) ||
                 ((r_state != S_IDLE) && w_cmd);
      case (r_state)
        S_IDLE: begin
          if (w_cmd) begin
            r_opcode    <= i_args[0];
            r_alias     <= i_args[1];
            r_value_str <= i_args[2];
            r_count_str <= i_args[3];
          end
        end
        S_DECODE: begin
          if (!w_dec_err) begin
            r_idx        <= w_idx;
            r_set[w_idx] <= w_value;
            if (w_is_pulse) begin
              r_saved <= r_set[w_idx];
              r_cnt   <= w_count;
            end
          end
        end
        S_PULSE: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_set[r_idx] <= r_saved;
        end
        default: ;
      endcase
    end
  end

  assign o_set   = r_set;
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = r_done;
  assign o_error = r_error;
  assign o_state = r_state;

endmodule

// File: tb/tb_set_level.sv
// Bench for set_level: table of single-shot commands plus hand-written
// sequences for pulses, busy collisions, truncation and asynchronous reset.
module tb_set_level;

  localparam int STR_W = 128;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0][STR_W-1:0] aliases;
  logic [4:0][STR_W-1:0] args;
  logic                  valid;
  logic                  sel_a, sel_b, sel_c;

  logic [4:0][31:0] set_a, set_c;
  logic [4:0][7:0]  set_b;
  logic busy_a, done_a, err_a;
  logic busy_b, done_b, err_b;
  logic busy_c, done_c, err_c;
  logic [1:0] state_a, state_b, state_c;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_a [5];

  set_level u_dut_a (
    .clk(clk), .rst(rst), .i_set_alias(aliases), .i_sel_set(sel_a),
    .i_args_valid(valid), .i_args(args), .o_set(set_a), .o_busy(busy_a),
    .o_done(done_a), .o_error(err_a), .o_state(state_a)
  );

  set_level #(.SET_WIDTH(8)) u_dut_b (
    .clk(clk), .rst(rst), .i_set_alias(aliases), .i_sel_set(sel_b),
    .i_args_valid(valid), .i_args(args), .o_set(set_b), .o_busy(busy_b),
    .o_done(done_b), .o_error(err_b), .o_state(state_b)
  );

  set_level #(.INIT_VALUE(32'd5)) u_dut_c (
    .clk(clk), .rst(rst), .i_set_alias(aliases), .i_sel_set(sel_c),
    .i_args_valid(valid), .i_args(args), .o_set(set_c), .o_busy(busy_c),
    .o_done(done_c), .o_error(err_c), .o_state(state_c)
  );

  typedef struct {
    string       op;
    string       al;
    string       va;
    string       cn;
    bit          err;
    int          slot;
    logic [31:0] val;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [STR_W-1:0] str(input string s);
    logic [STR_W-1:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r = {r[STR_W-9:0], s[i]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_a(input string name);
    for (int i = 0; i < 5; i++) chk($sformatf("%s slot%0d", name, i), set_a[i], exp_a[i]);
  endtask

  task automatic add(input string op, al, va, cn, input bit err, input int slot,
                     input logic [31:0] val);
    vec_t v;
    v.op = op; v.al = al; v.va = va; v.cn = cn; v.err = err; v.slot = slot; v.val = val;
    vecs.push_back(v);
  endtask

  // Driver: offer a command from a falling edge, hold it across one rising
  // edge, then withdraw it and scribble over the args at the next falling edge.
  task automatic issue(input int d, input string op, al, va, cn);
    args[0] = str(op); args[1] = str(al); args[2] = str(va); args[3] = str(cn);
    args[4] = '0;
    valid = 1'b1;
    sel_a = (d == 0); sel_b = (d == 1); sel_c = (d == 2);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; sel_a = 1'b0; sel_b = 1'b0; sel_c = 1'b0;
    args[1] = str("MODE"); args[2] = str("EE"); args[3] = str("1");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aliases[0] = str("EN");
    aliases[1] = str("RST_N");
    aliases[2] = str("DATA_IN");
    aliases[3] = str("MODE");
    aliases[4] = str("EN");
    args  = '0;
    valid = 1'b0;
    sel_a = 1'b0; sel_b = 1'b0; sel_c = 1'b0;
    for (int i = 0; i < 5; i++) exp_a[i] = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_a("reset a");
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset error", err_a, 0);
    chk("reset state", state_a, 0);
    for (int i = 0; i < 5; i++) chk("reset b", set_b[i], 0);
    for (int i = 0; i < 5; i++) chk("reset c init5", set_c[i], 5);
    rst = 1'b0;
    @(negedge clk);

    // Offer with only one of select/valid high: nothing is captured
    args[0] = str("SET"); args[1] = str("MODE"); args[2] = str("1");
    sel_a = 1'b1; valid = 1'b0;
    @(negedge clk);
    chk("sel only busy", busy_a, 0);
    sel_a = 1'b0; valid = 1'b1;
    @(negedge clk);
    chk("valid only busy", busy_a, 0);
    valid = 1'b0;
    @(negedge clk);
    chk_all_a("no capture");

    // Single-shot command table; each starts right on the done/error edge
    add("SET",       "DATA_IN", "A5A5",      "",   0, 2, 32'h0000A5A5);
    add("SET",       "UNKNOWN", "FF",        "",   1, 0, 32'h0);
    add("SET",       "DATA_IN", "1FFFFFFFF", "",   0, 2, 32'hFFFFFFFF);
    add("SET",       "MODE",    "ab",        "",   0, 3, 32'h000000AB);
    add("SET",       "MODE",    "AB",        "",   0, 3, 32'h000000AB);
    add("SET",       "EN",      "7",         "",   0, 0, 32'h00000007);
    add("BOGUS",     "MODE",    "1",         "",   1, 0, 32'h0);
    add("SET",       "MODE",    "XYZ",       "",   1, 0, 32'h0);
    add("SET",       "RST_N",   "",          "",   1, 0, 32'h0);
    add("SET_PULSE", "EN",      "1",         "0",  1, 0, 32'h0);
    add("SET_PULSE", "EN",      "1",         "",   1, 0, 32'h0);
    add("SET_PULSE", "EN",      "1",         "4x", 1, 0, 32'h0);
    add("SET",       "EN",      "0",         "",   0, 0, 32'h0);
    add("SET",       "RST_N",   "00000001",  "",   0, 1, 32'h00000001);

    foreach (vecs[n]) begin
      issue(0, vecs[n].op, vecs[n].al, vecs[n].va, vecs[n].cn);
      chk($sformatf("v%0d capture busy", n), busy_a, 1);
      chk($sformatf("v%0d capture state", n), state_a, 1);
      chk($sformatf("v%0d capture done", n), done_a, 0);
      chk($sformatf("v%0d capture error", n), err_a, 0);
      @(negedge clk);
      if (vecs[n].err) begin
        chk($sformatf("v%0d error", n), err_a, 1);
        chk($sformatf("v%0d error busy", n), busy_a, 0);
      end else begin
        exp_a[vecs[n].slot] = vecs[n].val;
        chk($sformatf("v%0d no error", n), err_a, 0);
        chk($sformatf("v%0d decode busy", n), busy_a, 1);
      end
      chk_all_a($sformatf("v%0d set", n));
      if (!vecs[n].err) begin
        @(negedge clk);
        chk($sformatf("v%0d done", n), done_a, 1);
        chk($sformatf("v%0d done busy", n), busy_a, 0);
      end
    end
    @(negedge clk);
    chk("table tail done", done_a, 0);
    chk("table tail error", err_a, 0);

    // Four-cycle pulse on EN (slot 0 currently 0)
    issue(0, "SET_PULSE", "EN", "1", "4");
    chk("p4 capture busy", busy_a, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_a[0] = (k <= 4) ? 32'd1 : 32'd0;
      chk_all_a($sformatf("p4 k%0d", k));
      chk($sformatf("p4 busy k%0d", k), busy_a, (k <= 5) ? 1 : 0);
      chk($sformatf("p4 done k%0d", k), done_a, (k == 6) ? 1 : 0);
    end

    // Ten-cycle pulse with a colliding command offered three cycles in
    issue(0, "SET_PULSE", "EN", "1", "10");
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_a[0] = (k <= 10) ? 32'd1 : 32'd0;
      chk_all_a($sformatf("p10 k%0d", k));
      chk($sformatf("p10 busy k%0d", k), busy_a, (k <= 11) ? 1 : 0);
      chk($sformatf("p10 done k%0d", k), done_a, (k == 12) ? 1 : 0);
      chk($sformatf("p10 error k%0d", k), err_a, (k == 4) ? 1 : 0);
      if (k == 3) begin
        args[0] = str("SET"); args[1] = str("MODE"); args[2] = str("7");
        valid = 1'b1; sel_a = 1'b1;
      end
      if (k == 4) begin
        valid = 1'b0; sel_a = 1'b0;
      end
    end

    // Truncation on an 8-bit instance
    issue(1, "SET", "DATA_IN", "3", "");
    @(negedge clk);
    chk("w8 set 3", set_b[2], 8'h03);
    chk("w8 other slot", set_b[0], 8'h00);
    chk("w8 leaves a idle", busy_a, 0);
    @(negedge clk);
    chk("w8 done", done_b, 1);
    issue(1, "SET", "DATA_IN", "1FF", "");
    @(negedge clk);
    chk("w8 truncate", set_b[2], 8'hFF);
    @(negedge clk);
    chk("w8 done2", done_b, 1);

    // Asynchronous reset in the middle of a pulse, INIT_VALUE = 5
    issue(2, "SET_PULSE", "MODE", "A", "6");
    @(negedge clk);
    chk("rst pulse c1", set_c[3], 32'hA);
    @(negedge clk);
    chk("rst pulse c2", set_c[3], 32'hA);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) chk("async rst init", set_c[i], 5);
    chk("async rst busy", busy_c, 0);
    chk("async rst state", state_c, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post rst done", done_c, 0);
      chk("post rst error", err_c, 0);
      chk("post rst level", set_c[3], 5);
    end
    issue(2, "SET", "MODE", "C", "");
    chk("post rst capture", busy_c, 1);
    @(negedge clk);
    chk("post rst set", set_c[3], 32'hC);
    @(negedge clk);
    chk("post rst cmd done", done_c, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
